apb5_completer_mem: RTL and testbench

//  Parametrised APB5 completer backed by a word-addressed memory, with programmable wait states.

---
 rtl/apb5_completer_pkg.sv | 17 +
 rtl/apb5_completer_mem_array.sv | 42 ++++
 rtl/apb5_completer_mem.sv | 172 +++++++++++++++++
 tb/tb_apb5_completer_mem.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb5_completer_pkg.sv
// Shared types and helpers for the APB5 memory-backed completer.
package apb5_completer_pkg;

    typedef enum logic {IDLE, ACCESS} state_e;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        DECODE   = 2'd1,
        SECURITY = 2'd2,
        STRB     = 2'd3
    } err_e;

    function automatic int unsigned addr_to_idx(input logic [31:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/apb5_completer_mem_array.sv
// Byte-enable data RAM plus per-word user array: sync write, async read, sync clear.
module apb5_completer_mem_array #(
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned USER_DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [IDX_WIDTH-1:0]       widx,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic [USER_DATA_WIDTH-1:0] wuser,
    input  logic [IDX_WIDTH-1:0]       ridx,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [USER_DATA_WIDTH-1:0] ruser
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]      mem  [DEPTH];
    logic [USER_DATA_WIDTH-1:0] user [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i]  <= '0;
                user[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
            if (wstrb != '0) user[widx] <= wuser;
        end
    end

    assign rdata = (32'(ridx) < DEPTH) ? mem[ridx]  : '0;
    assign ruser = (32'(ridx) < DEPTH) ? user[ridx] : '0;

endmodule

// File: rtl/apb5_completer_mem.sv
// APB5 completer: IDLE/ACCESS FSM, wait-state counter, decode/security checks, registered response.
module apb5_completer_mem
    import apb5_completer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 12,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEPTH           = 64,
    parameter int unsigned WAIT_STATES     = 0,
    parameter int unsigned SECURE_BASE     = 32,
    parameter int unsigned USER_DATA_WIDTH = 8,
    parameter int unsigned USER_RESP_WIDTH = 2
) (
    input  logic                       pclk,
    input  logic                       preset,
    input  logic                       psel,
    input  logic                       penable,
    input  logic [ADDR_WIDTH-1:0]      paddr,
    input  logic                       pwrite,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [2:0]                 pprot,
    input  logic                       pnse,
    input  logic [USER_DATA_WIDTH-1:0] pwuser,
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr,
    output logic [USER_DATA_WIDTH-1:0] pruser,
    output logic [USER_RESP_WIDTH-1:0] pbuser,
    output logic                       prot_err
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned LSB       = $clog2(BYTES);
    localparam int unsigned IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    state_e                     state;
    logic [3:0]                 wcnt;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic                       write_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic [BYTES-1:0]           strb_q;
    logic [USER_DATA_WIDTH-1:0] wuser_q;
    logic [IDX_WIDTH-1:0]       idx_q;
    err_e                       err_q;

    int unsigned                idx_now;
    logic [IDX_WIDTH-1:0]       idx_now_w;
    err_e                       err_now;
    err_e                       err_sel;
    logic                       wr_sel;
    logic                       rd_ok;
    logic [IDX_WIDTH-1:0]       ridx;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [USER_DATA_WIDTH-1:0] ruser;
    logic                       we;
    logic                       unused;

    assign idx_now   = addr_to_idx(32'(paddr), LSB);
    assign idx_now_w = IDX_WIDTH'(idx_now);
    assign unused    = ^{pprot[2], pprot[0]};

    always_comb begin
        err_now = OK;
        if (idx_now >= DEPTH || (paddr & ALIGN_MASK) != '0)
            err_now = DECODE;
        else if ((pnse && !pprot[1]) || (pprot[1] && idx_now >= SECURE_BASE))
            err_now = SECURITY;
        else if (!pwrite && pstrb != '0)
            err_now = STRB;
    end

    // With zero wait states the response loads on the SETUP edge, before anything is latched.
    assign err_sel = (state == IDLE) ? err_now   : err_q;
    assign wr_sel  = (state == IDLE) ? pwrite    : write_q;
    assign ridx    = (state == IDLE) ? idx_now_w : idx_q;
    assign rd_ok   = !wr_sel && (err_sel == OK);

    assign we = (state == ACCESS) && psel && penable && pready && write_q && (err_q == OK);

    apb5_completer_mem_array #(
        .DEPTH           (DEPTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .USER_DATA_WIDTH (USER_DATA_WIDTH),
        .IDX_WIDTH       (IDX_WIDTH)
    ) u_array (
        .clk   (pclk),
        .rst   (preset),
        .we    (we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .wuser (wuser_q),
        .ridx  (ridx),
        .rdata (rdata),
        .ruser (ruser)
    );

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            wcnt     <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wuser_q  <= '0;
            idx_q    <= '0;
            err_q    <= OK;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
            pruser   <= '0;
            pbuser   <= '0;
            prot_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pready <= 1'b0;
                    if (psel && !penable) begin
                        state   <= ACCESS;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        wuser_q <= pwuser;
                        idx_q   <= idx_now_w;
                        err_q   <= err_now;
                        wcnt    <= 4'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            pready  <= 1'b1;
                            prdata  <= rd_ok ? rdata : '0;
                            pruser  <= rd_ok ? ruser : '0;
                            pslverr <= (err_sel != OK);
                            pbuser  <= USER_RESP_WIDTH'(err_sel);
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        prot_err <= 1'b1;
                        pready   <= 1'b0;
                        pslverr  <= 1'b0;
                        pbuser   <= '0;
                        state    <= IDLE;
                    end else begin
                        if (paddr != addr_q || pwrite != write_q) prot_err <= 1'b1;
                        if (penable) begin
                            if (pready) begin
                                pready  <= 1'b0;
                                pslverr <= 1'b0;
                                pbuser  <= '0;
                                state   <= IDLE;
                            end else begin
                                wcnt <= 4'(wcnt - 4'd1);
                                if (wcnt == 4'd1) begin
                                    pready  <= 1'b1;
                                    prdata  <= rd_ok ? rdata : '0;
                                    pruser  <= rd_ok ? ruser : '0;
                                    pslverr <= (err_sel != OK);
                                    pbuser  <= USER_RESP_WIDTH'(err_sel);
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb5_completer_mem.sv
// Scoreboard bench for two completer instances: zero wait states (d=0) and three wait states (d=1).
module tb_apb5_completer_mem;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel0, psel3, penable, pwrite, pnse;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [7:0]  pwuser;

    logic        pready0, pslverr0, prot_err0, pready3, pslverr3, prot_err3;
    logic [31:0] prdata0, prdata3;
    logic [7:0]  pruser0, pruser3;
    logic [1:0]  pbuser0, pbuser3;

    typedef struct {
        logic [31:0] rdata;
        logic [7:0]  ruser;
        logic        slverr;
        logic [1:0]  buser;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [2][64];
    logic [7:0]  usr_m [2][64];
    int          total = 0;
    int          bad   = 0;

    always #5 pclk = ~pclk;

    apb5_completer_mem #(.WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pnse(pnse),
        .pwuser(pwuser), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0),
        .pruser(pruser0), .pbuser(pbuser0), .prot_err(prot_err0)
    );

    apb5_completer_mem #(.WAIT_STATES(3)) u_dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pnse(pnse),
        .pwuser(pwuser), .pready(pready3), .prdata(prdata3), .pslverr(pslverr3),
        .pruser(pruser3), .pbuser(pbuser3), .prot_err(prot_err3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready3;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) begin
                mem_m[d][i] = '0;
                usr_m[d][i] = '0;
            end
    endtask

    task automatic apb_xfer(input int d, input logic wr, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input logic nse, input logic [7:0] user);
        exp_t        e, g;
        int unsigned fidx;
        logic [1:0]  err;
        int          waits;

        fidx = 32'(addr) >> 2;
        if (fidx >= 64 || addr[1:0] != 2'b00)             err = 2'd1;
        else if ((nse && !prot[1]) || (prot[1] && fidx >= 32)) err = 2'd2;
        else if (!wr && strb != 4'h0)                    err = 2'd3;
        else                                             err = 2'd0;

        e.rdata  = (!wr && err == 2'd0) ? mem_m[d][fidx] : 32'h0;
        e.ruser  = (!wr && err == 2'd0) ? usr_m[d][fidx] : 8'h0;
        e.slverr = (err != 2'd0);
        e.buser  = err;
        sb_q.push_back(e);
        if (wr && err == 2'd0) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem_m[d][fidx][8*b +: 8] = data[8*b +: 8];
            if (strb != 4'h0) usr_m[d][fidx] = user;
        end

        @(posedge pclk); #1;
        if (d == 0) psel0 = 1'b1; else psel3 = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        pstrb = strb; pprot = prot; pnse = nse; pwuser = user;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (!rdy(d) && waits < 40) begin
            waits++;
            @(negedge pclk);
        end
        g = sb_q.pop_front();
        check_val("wait_cycles", 32'(waits), (d == 0) ? 32'd0 : 32'd3);
        check_val("prdata",  (d == 0) ? prdata0 : prdata3, g.rdata);
        check_val("pruser",  32'((d == 0) ? pruser0 : pruser3), 32'(g.ruser));
        check_val("pslverr", 32'((d == 0) ? pslverr0 : pslverr3), 32'(g.slverr));
        check_val("pbuser",  32'((d == 0) ? pbuser0 : pbuser3), 32'(g.buser));
        @(posedge pclk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check_val("idle_pready", 32'(rdy(d)), 32'd0);
    endtask

    initial begin
        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b000; pnse = 1'b0; pwuser = '0;
        clear_model();
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check_val("rst_pready",   32'({pready0, pready3}), 32'd0);
        check_val("rst_prdata",   prdata0 | prdata3, 32'd0);
        check_val("rst_pslverr",  32'({pslverr0, pslverr3}), 32'd0);
        check_val("rst_pbuser",   32'({pbuser0, pbuser3}), 32'd0);
        check_val("rst_prot_err", 32'({prot_err0, prot_err3}), 32'd0);

        // zero wait states: full write then readback
        apb_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, 8'hA5);
        apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        check_val("t1_const", prdata0, 32'hDEADBEEF);

        // three wait states, strobed writes, zero-strobe no-op
        apb_xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        apb_xfer(1, 1'b1, 12'h020, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, 8'h11);
        apb_xfer(1, 1'b1, 12'h020, 32'h12345678, 4'b0101, 3'b000, 1'b0, 8'h22);
        apb_xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        check_val("t3_const", prdata3, 32'hFF34FF78);
        apb_xfer(1, 1'b1, 12'h020, 32'h00000000, 4'h0, 3'b000, 1'b0, 8'h99);
        apb_xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);

        // error cases and priority
        apb_xfer(0, 1'b0, 12'h100, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        apb_xfer(0, 1'b0, 12'h011, 32'h0, 4'h0, 3'b010, 1'b1, 8'h00);
        apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h3, 3'b000, 1'b0, 8'h00);
        apb_xfer(0, 1'b1, 12'h0A0, 32'h5A5A5A5A, 4'hF, 3'b000, 1'b0, 8'h3C);
        apb_xfer(0, 1'b1, 12'h0A0, 32'h0BADF00D, 4'hF, 3'b010, 1'b0, 8'h77);
        apb_xfer(0, 1'b0, 12'h0A0, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 1'b1, 8'h00);
        apb_xfer(0, 1'b1, 12'h014, 32'hA1B2C3D4, 4'hF, 3'b010, 1'b0, 8'h42);
        apb_xfer(0, 1'b0, 12'h014, 32'h0, 4'h0, 3'b010, 1'b0, 8'h00);
        apb_xfer(0, 1'b0, 12'h0A0, 32'h0, 4'h3, 3'b010, 1'b1, 8'h00);

        // abort: psel dropped during the second ACCESS cycle of a write
        apb_xfer(1, 1'b1, 12'h030, 32'h11111111, 4'hF, 3'b000, 1'b0, 8'h01);
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF; pprot = 3'b000; pnse = 1'b0; pwuser = 8'hEE;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        @(negedge pclk);
        check_val("abort_prot_err", 32'(prot_err3), 32'd1);
        check_val("abort_pready",   32'(pready3), 32'd0);
        check_val("other_prot_err", 32'(prot_err0), 32'd0);
        apb_xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        check_val("sticky_prot_err", 32'(prot_err3), 32'd1);

        // reset asserted mid-ACCESS of a read
        @(posedge pclk); #1;
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h030; pstrb = 4'h0;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1 preset = 1'b1;
        @(posedge pclk); #1 preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        clear_model();
        @(negedge pclk);
        check_val("mrst_pready",   32'({pready0, pready3}), 32'd0);
        check_val("mrst_prdata",   prdata0 | prdata3, 32'd0);
        check_val("mrst_pruser",   32'({pruser0, pruser3}), 32'd0);
        check_val("mrst_pslverr",  32'({pslverr0, pslverr3}), 32'd0);
        check_val("mrst_pbuser",   32'({pbuser0, pbuser3}), 32'd0);
        check_val("mrst_prot_err", 32'({prot_err0, prot_err3}), 32'd0);
        apb_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        apb_xfer(1, 1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);
        apb_xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, 3'b000, 1'b0, 8'h00);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
